imem_responder: RTL and testbench
=================================

# imem_responder

Responder end of the instruction-fetch interface: accepts fetch requests (64-bit byte address) from the fetch stage and returns the 32-bit instruction word after a fixed, parameterised latency, with valid/ready flow control on both sides. Holds the instruction store, a program-load write port, a read-latency pipeline and a response FIFO. It replaces the bare combinational instruction memory behind the PC adder, so the pipeline can stall on fetch.

## Interface
- DEPTH_WORDS, 256: instruction store size in 32-bit words, power of two.
- LATENCY, 2: cycles from request acceptance to response visibility when the FIFO is empty; legal range 1..4.
- RSP_DEPTH, 4: response FIFO entries; also the maximum number of outstanding requests. Must be >= LATENCY.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted at an edge where req_valid && req_ready.
- req_addr  in  64  byte address of the instruction.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response at an edge where rsp_valid && rsp_ready.
- rsp_instr  out  32  instruction word; 0 when rsp_err.
- rsp_addr  out  64  req_addr echoed for this response.
- rsp_err  out  1  misaligned or out-of-range fetch.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  clog2(DEPTH_WORDS)  word index to write.
- ld_data  in  32  word to write.

## Operation
- Word index = req_addr[AW+1:2], where AW = clog2(DEPTH_WORDS).
- rsp_err = (req_addr[1:0] != 0) || (req_addr >= 4*DEPTH_WORDS). On an error, no store read is used and rsp_instr = 0.
- The store is read at the acceptance edge. Data and the error flag then travel through LATENCY-1 delay registers, each with a valid bit, and are pushed into the response FIFO.
- Outputs are driven from the FIFO head and registered. There is no bypass around the FIFO.
- Credits:
  - outstanding = pipeline valid count + FIFO count.
  - req_ready = !ld_en && (outstanding < RSP_DEPTH).
  - A pop in the current cycle does not free a credit until the next cycle, so there is no combinational path from rsp_ready to req_ready.
  - The FIFO therefore can never overflow.
- Loads:
  - ld_en writes ld_data to store[ld_addr] at the edge.
  - ld_en forces req_ready low, so a load and a read never collide.
  - Requests already in flight keep the data read at their acceptance.
- Ordering: responses return strictly in request order.

## Timing
- Reset values: req_ready 0 while reset is asserted, 1 in the first cycle after release (assuming ld_en low). rsp_valid 0, rsp_instr 0, rsp_addr 0, rsp_err 0. FIFO empty, all pipeline valid bits 0.
- Store contents are not reset.
- Latency: request accepted at edge T with the FIFO empty gives rsp_valid = 1 after edge T+LATENCY.
- Throughput: one request per cycle sustained when rsp_ready is held high.
- Backpressure: with rsp_ready low, the block accepts exactly RSP_DEPTH requests, then holds req_ready low. rsp_* stay stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop on the FIFO is legal at any occupancy, including full.
- Read and write pointers wrap modulo RSP_DEPTH.
- Reset mid-operation drops all in-flight and queued responses immediately, asynchronously.

## Structure
- Package imem_pkg holds:
  - INSTR_W = 32 and ADDR_W = 64.
  - A packed response typedef {err, addr[63:0], instr[31:0]}.
  - Function word_index(addr).
- Sub-module resp_fifo: parameterised by depth and element type, with push/pop/count ports and async active-high reset. Instantiated once.
- The delay pipeline and store stay inline.

## Test plan
- Load 0x8B020020 at word 5 and 0xD503201F at word 6, then request 0x14 and 0x18 back-to-back with rsp_ready = 1. Expect responses at T+2 and T+3 carrying those instr values, rsp_addr echoed, rsp_err = 0.
- Hold rsp_ready = 0 and stream requests. Expect exactly 4 accepted, then req_ready = 0. Release rsp_ready: 4 in-order responses, and req_ready returns the cycle after the first pop.
- Request 0x16 (misaligned) and 0x400 (out of range with DEPTH_WORDS = 256). Expect rsp_err = 1 and rsp_instr = 0 for both.
- Assert ld_en for 3 cycles while req_valid is high. Expect req_ready = 0 throughout. The first request after the load returns the newly written word.
- Assert reset with 2 in flight and 2 queued. Expect rsp_valid = 0 immediately. After release, the next request returns with latency 2 and no stale data. Stored words survive reset.
- Run with LATENCY = 1: a request at edge T is visible after T+1, with sustained 1 per cycle while rsp_ready = 1.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | imem_pkg : shared widths, response record and index helper      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef struct packed {
    logic               err;
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } imem_rsp_t;

  // Full-width word index; callers keep only the bits their store needs.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | resp_fifo : register-based FIFO, any depth, generic element     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  T                             push_data_i,
  input  logic                         pop_i,
  output T                             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full;
  logic           do_pop;
  logic           do_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A pop at full frees the slot the same edge, so push+pop at full is legal.
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | imem_responder : instruction store with fixed-latency, flow-    |
// | controlled fetch responses.                    Rev 1.0          |
// +-----------------------------------------------------------------+
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ADDR_W-1:0]              req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [INSTR_W-1:0]             rsp_instr_o,
  output logic [ADDR_W-1:0]              rsp_addr_o,
  output logic                           rsp_err_o,
  input  logic                           ld_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_i,
  input  logic [INSTR_W-1:0]             ld_data_i
);

  localparam int                AW         = $clog2(DEPTH_WORDS);
  localparam int                CW         = $clog2(RSP_DEPTH + 1);
  localparam int                OW         = CW + 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH_WORDS);

  logic [INSTR_W-1:0] store_q [DEPTH_WORDS];

  logic [AW-1:0]      idx;
  logic               addr_err;
  logic               accept;
  imem_rsp_t          entry;

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  imem_rsp_t          pipe_q [LATENCY];

  logic [OW-1:0]      pipe_cnt;
  logic [OW-1:0]      outstanding;
  logic [CW-1:0]      fifo_cnt;
  logic               fifo_pop;
  imem_rsp_t          head;

  always_ff @(posedge clk_i) begin
    if (ld_en_i) store_q[ld_addr_i] <= ld_data_i;
  end

  assign idx      = AW'(word_index(req_addr_i));
  assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= ADDR_LIMIT);
  assign accept   = req_valid_i && req_ready_o;

  always_comb begin
    entry      = '0;
    entry.err  = addr_err;
    entry.addr = req_addr_i;
    if (!addr_err) entry.instr = store_q[idx];
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign pipe_vld_d = accept;
    end else begin : g_latn
      assign pipe_vld_d = {pipe_vld_q[LATENCY-2:0], accept};
    end
  endgenerate

  // Stage 0 is the store read register; later stages only delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      if (accept) pipe_q[0] <= entry;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LATENCY; i++) pipe_cnt = pipe_cnt + OW'(pipe_vld_q[i]);
  end

  // Credits come only from registered counts, so rsp_ready never reaches req_ready.
  assign outstanding = pipe_cnt + OW'(fifo_cnt);
  assign req_ready_o = !rst_i && !ld_en_i && (outstanding < OW'(RSP_DEPTH));

  resp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (imem_rsp_t)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pipe_vld_q[LATENCY-1]),
    .push_data_i (pipe_q[LATENCY-1]),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  assign rsp_valid_o = (fifo_cnt != '0);
  assign fifo_pop    = rsp_valid_o && rsp_ready_i;
  assign rsp_instr_o = head.instr;
  assign rsp_addr_o  = head.addr;
  assign rsp_err_o   = head.err;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_imem_responder : two instances (latency 2 and 1) against a   |
// | queue-based reference model.                   Rev 1.0          |
// +-----------------------------------------------------------------+
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DW   = 256;
  localparam int RSPD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_instr [2];
  logic [63:0] rsp_addr  [2];
  logic        rsp_err   [2];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DW), .LATENCY(2), .RSP_DEPTH(RSPD)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr[0]), .rsp_addr_o(rsp_addr[0]), .rsp_err_o(rsp_err[0]),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  imem_responder #(.DEPTH_WORDS(DW), .LATENCY(1), .RSP_DEPTH(RSPD)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr[1]), .rsp_addr_o(rsp_addr[1]), .rsp_err_o(rsp_err[1]),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  // Reference model: word array plus per-instance ordered queue of expected responses.
  logic [31:0] mem_m    [DW];
  logic [31:0] sb_instr [2][64];
  logic [63:0] sb_addr  [2][64];
  logic        sb_err   [2][64];
  int          sb_t     [2][64];
  int          wr [2];
  int          rd [2];
  int          cyc;

  // Log of responses actually handed over by each instance.
  logic [31:0] pl_instr [2][512];
  logic [63:0] pl_addr  [2][512];
  logic        pl_err   [2][512];
  int          pl_cyc   [2][512];
  int          pop_n [2];
  int          dut_acc [2];

  int n_chk;
  int n_fail;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;
  vec_t tbl [8];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic ref_err(input logic [63:0] a);
    return ((a % 64'd4) != 64'd0) || (a >= 64'(4 * DW));
  endfunction

  function automatic logic [31:0] ref_instr(input logic [63:0] a);
    if (ref_err(a)) return 32'd0;
    return mem_m[int'(a / 64'd4)];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs set; checks at +2, advances one edge, returns at posedge+1.
  task automatic step();
    logic        er [2];
    logic        ev [2];
    logic        sv [2];
    logic [31:0] si [2];
    logic [63:0] sa [2];
    logic        se [2];
    int          j;
    #1;
    for (int d = 0; d < 2; d++) begin
      er[d] = !ld_en && ((wr[d] - rd[d]) < RSPD);
      ev[d] = (wr[d] != rd[d]) && (sb_t[d][rd[d] % 64] <= cyc);
      sv[d] = rsp_valid[d];
      si[d] = rsp_instr[d];
      sa[d] = rsp_addr[d];
      se[d] = rsp_err[d];
      chk($sformatf("req_ready[%0d]", d), 64'(req_ready[d]), 64'(er[d]));
      chk($sformatf("rsp_valid[%0d]", d), 64'(sv[d]), 64'(ev[d]));
      if (ev[d]) begin
        j = rd[d] % 64;
        chk($sformatf("rsp_instr[%0d]", d), 64'(si[d]), 64'(sb_instr[d][j]));
        chk($sformatf("rsp_addr[%0d]", d), sa[d], sb_addr[d][j]);
        chk($sformatf("rsp_err[%0d]", d), 64'(se[d]), 64'(sb_err[d][j]));
      end
      if (req_valid && req_ready[d]) dut_acc[d]++;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (sv[d] && rsp_ready) begin
        j = pop_n[d] % 512;
        pl_instr[d][j] = si[d];
        pl_addr[d][j]  = sa[d];
        pl_err[d][j]   = se[d];
        pl_cyc[d][j]   = cyc;
        pop_n[d]++;
      end
      if (ev[d] && rsp_ready) rd[d]++;
    end
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (req_valid && er[d]) begin
        j = wr[d] % 64;
        sb_instr[d][j] = ref_instr(req_addr);
        sb_addr[d][j]  = req_addr;
        sb_err[d][j]   = ref_err(req_addr);
        sb_t[d][j]     = cyc + lat_of(d);
        wr[d]++;
      end
    end
    if (ld_en) mem_m[ld_addr] = ld_data;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_rst_valid[%0d]", d), 64'(rsp_valid[d]), 64'd0);
      chk($sformatf("async_rst_ready[%0d]", d), 64'(req_ready[d]), 64'd0);
      wr[d] = 0;
      rd[d] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_pop(input int n0, input string name);
    for (int k = 0; k < 12 && pop_n[0] == n0; k++) step();
    chk(name, 64'(pop_n[0] - n0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int n [2];
    int p;
    int r;

    n_chk = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0; rd[d] = 0; pop_n[d] = 0; dut_acc[d] = 0;
    end
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready[%0d]", d), 64'(req_ready[d]), 64'd0);
      chk($sformatf("rst_rsp_valid[%0d]", d), 64'(rsp_valid[d]), 64'd0);
      chk($sformatf("rst_rsp_instr[%0d]", d), 64'(rsp_instr[d]), 64'd0);
      chk($sformatf("rst_rsp_addr[%0d]", d), rsp_addr[d], 64'd0);
      chk($sformatf("rst_rsp_err[%0d]", d), 64'(rsp_err[d]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Program load: whole store random, then known words.
    for (int w = 0; w < DW; w++) begin
      ld_en = 1'b1; ld_addr = 8'(w); ld_data = $urandom; step();
    end
    ld_addr = 8'd5;   ld_data = 32'h8B02_0020; step();
    ld_addr = 8'd6;   ld_data = 32'hD503_201F; step();
    ld_addr = 8'd255; ld_data = 32'hCAFE_F00D; step();
    ld_en = 1'b0;

    // Back-to-back fetch, latency and throughput on both instances.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h14;
    a0 = cyc + 1; n[0] = pop_n[0]; n[1] = pop_n[1];
    step();
    req_addr = 64'h18; step();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t1_count[%0d]", d), 64'(pop_n[d] - n[d]), 64'd2);
      p = n[d] % 512;
      chk($sformatf("t1_instr0[%0d]", d), 64'(pl_instr[d][p]), 64'h8B02_0020);
      chk($sformatf("t1_addr0[%0d]", d), pl_addr[d][p], 64'h14);
      chk($sformatf("t1_err0[%0d]", d), 64'(pl_err[d][p]), 64'd0);
      chk($sformatf("t1_latency[%0d]", d), 64'(pl_cyc[d][p] - a0), 64'(lat_of(d)));
      chk($sformatf("t1_instr1[%0d]", d), 64'(pl_instr[d][(p+1)%512]), 64'hD503_201F);
      chk($sformatf("t1_addr1[%0d]", d), pl_addr[d][(p+1)%512], 64'h18);
      chk($sformatf("t1_back2back[%0d]", d), 64'(pl_cyc[d][(p+1)%512] - pl_cyc[d][p]), 64'd1);
    end

    // Backpressure: exactly RSPD accepted, then in-order drain.
    rsp_ready = 1'b0; req_valid = 1'b1;
    dut_acc[0] = 0; dut_acc[1] = 0; n[0] = pop_n[0]; n[1] = pop_n[1];
    for (int k = 0; k < 8; k++) begin
      req_addr = 64'(k * 4); step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_accepted[%0d]", d), 64'(dut_acc[d]), 64'(RSPD));
      chk($sformatf("bp_drained[%0d]", d), 64'(pop_n[d] - n[d]), 64'(RSPD));
      for (int k = 0; k < RSPD; k++)
        chk($sformatf("bp_order[%0d][%0d]", d, k), pl_addr[d][(n[d]+k)%512], 64'(k * 4));
    end

    // Table of fetch addresses, including error boundaries.
    tbl[0] = '{64'h14,                  32'h8B02_0020, 1'b0};
    tbl[1] = '{64'h16,                  32'h0,         1'b1};
    tbl[2] = '{64'h400,                 32'h0,         1'b1};
    tbl[3] = '{64'h18,                  32'hD503_201F, 1'b0};
    tbl[4] = '{64'h3FC,                 32'hCAFE_F00D, 1'b0};
    tbl[5] = '{64'h3FD,                 32'h0,         1'b1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h0,         1'b1};
    tbl[7] = '{64'h1_0000_0014,         32'h0,         1'b1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n[0] = pop_n[0];
      req_valid = 1'b1; req_addr = tbl[i].addr; step();
      req_valid = 1'b0;
      wait_pop(n[0], $sformatf("tbl_rsp_seen[%0d]", i));
      p = n[0] % 512;
      chk($sformatf("tbl_instr[%0d]", i), 64'(pl_instr[0][p]), 64'(tbl[i].instr));
      chk($sformatf("tbl_err[%0d]", i), 64'(pl_err[0][p]), 64'(tbl[i].err));
      chk($sformatf("tbl_addr[%0d]", i), pl_addr[0][p], tbl[i].addr);
    end
    for (int k = 0; k < 4; k++) step();

    // Load while a request waits: ready held low, then new word returned.
    req_valid = 1'b1; req_addr = 64'h24;
    for (int k = 0; k < 3; k++) begin
      ld_en = 1'b1; ld_addr = 8'd9; ld_data = (k == 2) ? 32'h1234_5678 : 32'(k);
      #1;
      chk($sformatf("ld_ready_low[%0d]", k), 64'(req_ready[0]), 64'd0);
      step();
    end
    ld_en = 1'b0; n[0] = pop_n[0];
    step();
    req_valid = 1'b0;
    wait_pop(n[0], "ld_rsp_seen");
    chk("ld_new_word", 64'(pl_instr[0][n[0] % 512]), 64'h1234_5678);

    // Reset with two queued and two in flight.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h14;
    for (int k = 0; k < 4; k++) step();
    req_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(rsp_valid[0]), 64'd1);
    do_reset();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h18;
    a0 = cyc + 1; n[0] = pop_n[0]; n[1] = pop_n[1];
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    for (int d = 0; d < 2; d++) begin
      p = n[d] % 512;
      chk($sformatf("post_rst_count[%0d]", d), 64'(pop_n[d] - n[d]), 64'd1);
      chk($sformatf("post_rst_addr[%0d]", d), pl_addr[d][p], 64'h18);
      chk($sformatf("post_rst_instr[%0d]", d), 64'(pl_instr[d][p]), 64'hD503_201F);
      chk($sformatf("post_rst_latency[%0d]", d), 64'(pl_cyc[d][p] - a0), 64'(lat_of(d)));
    end

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 4) != 0;
      ld_en     = ($urandom % 16) == 0;
      ld_addr   = 8'($urandom);
      ld_data   = $urandom;
      r = int'($urandom % 8);
      if (r < 6)       req_addr = 64'($urandom_range(0, DW - 1)) * 64'd4;
      else if (r == 6) req_addr = 64'($urandom_range(0, 4 * DW - 1));
      else             req_addr = {$urandom, $urandom};
      step();
    end
    req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
